// File: rtl/counter_scheduler_if.sv
// Bus bundle between the requesting control units and counter_scheduler.
// master: requester side (drives req/len/pause, observes grant and counter).
// slave : scheduler side (samples requests, drives grant, counter and done).
interface counter_scheduler_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 4
) ();
    localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] len;
    logic                  pause;
    logic [NREQ-1:0]       gnt;
    logic [OW-1:0]         owner;
    logic                  busy;
    logic [WIDTH-1:0]      count;
    logic [NREQ-1:0]       done;

    modport master (
        output req, len, pause,
        input  gnt, owner, busy, count, done
    );

    modport slave (
        input  req, len, pause,
        output gnt, owner, busy, count, done
    );
endinterface

// File: rtl/counter_scheduler.sv
// counter_scheduler: round-robin sharing of one up-counter among NREQ
// requesters. A granted requester gets a count run from 0 up to its latched
// target; the run is sequenced IDLE -> RUN -> DONE and finishes with a
// one-cycle done pulse to the owner. Every output is a flop.
//
// Optional feature macro: COUNTER_SCHEDULER_ABORT_EN
//   When defined, the owner dropping its req during RUN aborts the run
//   (back to IDLE, no done pulse, count frozen). When undefined, req is not
//   looked at during RUN and every run completes through DONE.
module counter_scheduler #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 4
) (
    input  logic                 clock,
    input  logic                 clear_n,
    counter_scheduler_if.slave   bus
);
    localparam int OW = $clog2(NREQ);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    state_t            state_r;
    logic [NREQ-1:0]   gnt_r;
    logic [NREQ-1:0]   done_r;
    logic [OW-1:0]     owner_r;
    logic [OW-1:0]     last_owner_r;
    logic              busy_r;
    logic [WIDTH-1:0]  count_r;
    logic [WIDTH-1:0]  target_r;

    logic [OW-1:0]     winner_s;
    logic              found_s;
    logic              abort_s;
    logic              at_target_s;

    // One-hot decode of a requester index.
    function automatic logic [NREQ-1:0] onehot_f(input logic [OW-1:0] idx);
        logic [NREQ-1:0] v;
        v      = {NREQ{1'b0}};
        v[idx] = 1'b1;
        return v;
    endfunction

    // Round-robin search: walk downward from the farthest candidate so the
    // closest set req after last_owner is the one left standing.
    always_comb begin
        int idx;
        idx      = 0;
        winner_s = {OW{1'b0}};
        found_s  = 1'b0;
        for (int k = NREQ; k >= 1; k--) begin
            idx      = (int'(last_owner_r) + k) % NREQ;
            winner_s = bus.req[idx] ? OW'(idx) : winner_s;
            found_s  = found_s | bus.req[idx];
        end
    end

`ifdef COUNTER_SCHEDULER_ABORT_EN
    // Owner withdrawing its request ends the run early.
    assign abort_s = ~bus.req[owner_r];
`else
    // Requests are not monitored once a run has started.
    assign abort_s = 1'b0;
`endif

    assign at_target_s = (count_r == target_r);

    // Scheduler FSM with all outputs registered alongside the state.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state_r      <= ST_IDLE;
            gnt_r        <= {NREQ{1'b0}};
            done_r       <= {NREQ{1'b0}};
            busy_r       <= 1'b0;
            count_r      <= {WIDTH{1'b0}};
            target_r     <= {WIDTH{1'b0}};
            owner_r      <= {OW{1'b0}};
            last_owner_r <= OW'(NREQ - 1);
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= {NREQ{1'b0}};
                    if (found_s) begin
                        // Target is latched here so later len changes are ignored.
                        target_r <= bus.len[int'(winner_s)*WIDTH +: WIDTH];
                        count_r  <= {WIDTH{1'b0}};
                        owner_r  <= winner_s;
                        gnt_r    <= onehot_f(winner_s);
                        busy_r   <= 1'b1;
                        state_r  <= ST_RUN;
                    end else begin
                        gnt_r    <= {NREQ{1'b0}};
                        busy_r   <= 1'b0;
                        state_r  <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (abort_s) begin
                        // Abort beats reaching the target in the same cycle.
                        gnt_r        <= {NREQ{1'b0}};
                        busy_r       <= 1'b0;
                        last_owner_r <= owner_r;
                        state_r      <= ST_IDLE;
                    end else if (at_target_s) begin
                        // Finishing is not held off by pause.
                        gnt_r   <= {NREQ{1'b0}};
                        done_r  <= onehot_f(owner_r);
                        state_r <= ST_DONE;
                    end else if (!bus.pause) begin
                        count_r <= count_r + {{(WIDTH-1){1'b0}}, 1'b1};
                    end else begin
                        count_r <= count_r;
                    end
                end
                ST_DONE: begin
                    // Rotating last_owner is what keeps waiting requesters ahead.
                    done_r       <= {NREQ{1'b0}};
                    gnt_r        <= {NREQ{1'b0}};
                    busy_r       <= 1'b0;
                    last_owner_r <= owner_r;
                    state_r      <= ST_IDLE;
                end
                default: begin
                    // Spare encoding recovers to a quiet IDLE.
                    gnt_r   <= {NREQ{1'b0}};
                    done_r  <= {NREQ{1'b0}};
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.gnt   = gnt_r;
    assign bus.done  = done_r;
    assign bus.owner = owner_r;
    assign bus.busy  = busy_r;
    assign bus.count = count_r;
endmodule

// File: tb/tb_counter_scheduler.sv
// Directed bench for counter_scheduler (NREQ=4, WIDTH=4): a cycle table for
// the single-requester runs plus hand-written multi-cycle sequences.
module tb_counter_scheduler;
    logic clock;
    logic clear_n;
    int   tests;
    int   fails;

    counter_scheduler_if #(.NREQ(4), .WIDTH(4)) bus ();

    counter_scheduler #(.NREQ(4), .WIDTH(4)) dut (
        .clock   (clock),
        .clear_n (clear_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [3:0]  req;
        logic [15:0] len;
        logic        pause;
        logic [3:0]  gnt;
        logic [3:0]  cnt;
        logic        busy;
        logic [3:0]  done;
        logic [1:0]  owner;
    } vec_t;

    vec_t       tbl[$];
    logic [3:0] done_q[$];
    logic [3:0] cnt_q[$];

    function automatic vec_t v(input logic [3:0] req, input logic [15:0] len,
                               input logic pause, input logic [3:0] gnt,
                               input logic [3:0] cnt, input logic busy,
                               input logic [3:0] done, input logic [1:0] owner);
        vec_t r;
        r.req = req; r.len = len; r.pause = pause; r.gnt = gnt;
        r.cnt = cnt; r.busy = busy; r.done = done; r.owner = owner;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    // Runs until n done pulses are seen (or budget expires), logging each
    // pulse and the count shown with it; drops all requests after the last.
    task automatic wait_dones(input int n, input int budget);
        int got;
        int cyc;
        int multi;
        got = 0; cyc = 0; multi = 0;
        done_q.delete();
        cnt_q.delete();
        while (got < n && cyc < budget) begin
            step();
            cyc++;
            if (!$onehot0(bus.gnt)) multi++;
            if (bus.done != 4'b0000) begin
                done_q.push_back(bus.done);
                cnt_q.push_back(bus.count);
                got++;
            end
        end
        bus.req = 4'b0000;
        check("dones_seen", 32'(got), 32'(n));
        check("gnt_onehot", 32'(multi), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] exp_order[4];
        int         cyc;

        tests = 0;
        fails = 0;
        bus.req = 4'b0000; bus.len = 16'h0000; bus.pause = 1'b0;
        clear_n = 1'b0;
        repeat (2) @(negedge clock);
        clear_n = 1'b1;
        step();
        check("rst gnt",   32'(bus.gnt),   32'd0);
        check("rst done",  32'(bus.done),  32'd0);
        check("rst busy",  32'(bus.busy),  32'd0);
        check("rst count", 32'(bus.count), 32'd0);
        check("rst owner", 32'(bus.owner), 32'd0);

        // req0 len 3; req1 len 5 with two pause cycles and a mid-run len change;
        // req3 len 0.
        tbl.push_back(v(4'h1, 16'h0003, 1'b0, 4'h1, 4'd0, 1'b1, 4'h0, 2'd0));
        tbl.push_back(v(4'h1, 16'h0003, 1'b0, 4'h1, 4'd1, 1'b1, 4'h0, 2'd0));
        tbl.push_back(v(4'h1, 16'h0003, 1'b0, 4'h1, 4'd2, 1'b1, 4'h0, 2'd0));
        tbl.push_back(v(4'h1, 16'h0003, 1'b0, 4'h1, 4'd3, 1'b1, 4'h0, 2'd0));
        tbl.push_back(v(4'h1, 16'h0003, 1'b0, 4'h0, 4'd3, 1'b1, 4'h1, 2'd0));
        tbl.push_back(v(4'h0, 16'h0003, 1'b0, 4'h0, 4'd3, 1'b0, 4'h0, 2'd0));
        tbl.push_back(v(4'h0, 16'h0003, 1'b0, 4'h0, 4'd3, 1'b0, 4'h0, 2'd0));
        tbl.push_back(v(4'h2, 16'h0050, 1'b0, 4'h2, 4'd0, 1'b1, 4'h0, 2'd1));
        tbl.push_back(v(4'h2, 16'h00F0, 1'b0, 4'h2, 4'd1, 1'b1, 4'h0, 2'd1));
        tbl.push_back(v(4'h2, 16'h00F0, 1'b0, 4'h2, 4'd2, 1'b1, 4'h0, 2'd1));
        tbl.push_back(v(4'h2, 16'h00F0, 1'b1, 4'h2, 4'd2, 1'b1, 4'h0, 2'd1));
        tbl.push_back(v(4'h2, 16'h00F0, 1'b1, 4'h2, 4'd2, 1'b1, 4'h0, 2'd1));
        tbl.push_back(v(4'h2, 16'h00F0, 1'b0, 4'h2, 4'd3, 1'b1, 4'h0, 2'd1));
        tbl.push_back(v(4'h2, 16'h00F0, 1'b0, 4'h2, 4'd4, 1'b1, 4'h0, 2'd1));
        tbl.push_back(v(4'h2, 16'h00F0, 1'b0, 4'h2, 4'd5, 1'b1, 4'h0, 2'd1));
        tbl.push_back(v(4'h2, 16'h00F0, 1'b1, 4'h0, 4'd5, 1'b1, 4'h2, 2'd1));
        tbl.push_back(v(4'h0, 16'h00F0, 1'b0, 4'h0, 4'd5, 1'b0, 4'h0, 2'd1));
        tbl.push_back(v(4'h8, 16'h0000, 1'b0, 4'h8, 4'd0, 1'b1, 4'h0, 2'd3));
        tbl.push_back(v(4'h8, 16'h0000, 1'b0, 4'h0, 4'd0, 1'b1, 4'h8, 2'd3));
        tbl.push_back(v(4'h0, 16'h0000, 1'b0, 4'h0, 4'd0, 1'b0, 4'h0, 2'd3));

        for (int i = 0; i < tbl.size(); i++) begin
            bus.req = tbl[i].req; bus.len = tbl[i].len; bus.pause = tbl[i].pause;
            step();
            check($sformatf("row%0d gnt", i),   32'(bus.gnt),   32'(tbl[i].gnt));
            check($sformatf("row%0d count", i), 32'(bus.count), 32'(tbl[i].cnt));
            check($sformatf("row%0d busy", i),  32'(bus.busy),  32'(tbl[i].busy));
            check($sformatf("row%0d done", i),  32'(bus.done),  32'(tbl[i].done));
            check($sformatf("row%0d owner", i), 32'(bus.owner), 32'(tbl[i].owner));
        end

        // Fairness: req0 and req2 held, last owner 3 -> 0,2,0,2.
        bus.len = 16'h0101; bus.req = 4'b0101;
        wait_dones(4, 100);
        exp_order[0] = 4'h1; exp_order[1] = 4'h4; exp_order[2] = 4'h1; exp_order[3] = 4'h4;
        for (int i = 0; i < 4; i++) begin
            if (i < done_q.size()) begin
                check($sformatf("rr done%0d", i),  32'(done_q[i]), 32'(exp_order[i]));
                check($sformatf("rr count%0d", i), 32'(cnt_q[i]),  32'd1);
            end
        end
        step();

        // Full-scale targets, all requesting, last owner 2 -> 3,0,1,2.
        bus.len = 16'hFFFF; bus.req = 4'b1111;
        wait_dones(4, 200);
        exp_order[0] = 4'h8; exp_order[1] = 4'h1; exp_order[2] = 4'h2; exp_order[3] = 4'h4;
        for (int i = 0; i < 4; i++) begin
            if (i < done_q.size()) begin
                check($sformatf("max done%0d", i),  32'(done_q[i]), 32'(exp_order[i]));
                check($sformatf("max count%0d", i), 32'(cnt_q[i]),  32'd15);
            end
        end
        step();
        check("max idle busy",  32'(bus.busy),  32'd0);
        check("max idle count", 32'(bus.count), 32'd15);

        // Reset mid-run on requester 2 (last owner 2 -> only req2 asks).
        bus.len = 16'h0A00; bus.req = 4'b0100;
        repeat (4) step();
        check("pre_rst gnt",   32'(bus.gnt),   32'h4);
        check("pre_rst count", 32'(bus.count), 32'd3);
        #2 clear_n = 1'b0;
        #1;
        check("mid_rst gnt",   32'(bus.gnt),   32'd0);
        check("mid_rst done",  32'(bus.done),  32'd0);
        check("mid_rst busy",  32'(bus.busy),  32'd0);
        check("mid_rst count", 32'(bus.count), 32'd0);
        check("mid_rst owner", 32'(bus.owner), 32'd0);
        bus.req = 4'b0000;
        @(negedge clock);
        clear_n = 1'b1;

        // req0 len 9 with req1 pending; req0 drops at count 4.
        bus.len = 16'h0029; bus.req = 4'b0011;
        cyc = 0;
        step();
        while (!(bus.gnt == 4'b0001 && bus.count == 4'd4) && cyc < 20) begin
            step();
            cyc++;
        end
        check("abort reach4", 32'(cyc < 20), 32'd1);
        bus.req = 4'b0010;
        step();
`ifdef COUNTER_SCHEDULER_ABORT_EN
        check("abort gnt",   32'(bus.gnt),   32'd0);
        check("abort done",  32'(bus.done),  32'd0);
        check("abort busy",  32'(bus.busy),  32'd0);
        check("abort count", 32'(bus.count), 32'd4);
        step();
        check("abort next gnt",   32'(bus.gnt),   32'h2);
        check("abort next count", 32'(bus.count), 32'd0);
        check("abort next owner", 32'(bus.owner), 32'd1);
`else
        check("noabort gnt",   32'(bus.gnt),   32'h1);
        check("noabort count", 32'(bus.count), 32'd5);
        cyc = 0;
        while (bus.done == 4'b0000 && cyc < 20) begin
            step();
            cyc++;
        end
        check("noabort done",       32'(bus.done),  32'h1);
        check("noabort done count", 32'(bus.count), 32'd9);
        step();
        check("noabort idle gnt", 32'(bus.gnt), 32'd0);
        step();
        check("noabort next gnt",   32'(bus.gnt),   32'h2);
        check("noabort next owner", 32'(bus.owner), 32'd1);
`endif
        bus.req = 4'b0000;
        repeat (6) step();
        check("final busy", 32'(bus.busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
